// File: rtl/tcp_vlg_rx_buf.sv
// Receive-side TCP payload buffer: circular RAM indexed by sequence number, commit on good segment end,
// advertised window tracking and a first-word-fall-through byte stream to the user.
module tcp_vlg_rx_buf #(
   parameter int D = 16,
   parameter int W = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          init,
   input  logic [31:0]   isn,
   input  logic          in_val,
   input  logic          in_sof,
   input  logic          in_eof,
   input  logic [31:0]   in_seq,
   input  logic          in_ok,
   input  logic [W-1:0]  in_dat,
   output logic [31:0]   rcv_nxt,
   output logic [15:0]   wnd,
   output logic          out_val,
   input  logic          out_rdy,
   output logic [W-1:0]  out_dat,
   output logic          f,
   output logic          e
);

   typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

   localparam logic [31:0]  CAP     = (32'd1 << D) - 32'd1;
   localparam logic [15:0]  WND_MAX = (CAP > 32'h0000_FFFF) ? 16'hFFFF : CAP[15:0];
   localparam logic [D:0]   ONE     = 1;
   localparam logic [D-1:0] A_ONE   = 1;

   state_t        state;
   logic [W-1:0]  mem [0:(1<<D)-1];
   logic [31:0]   rd_seq, fetch_seq;
   logic [D-1:0]  wp;
   logic [D:0]    cnt;
   logic          ovf;
   logic [W-1:0]  ram_q, skid_dat;
   logic          rd_pend, skid_val;

   logic [D:0]    used, space, used_d, space_d;
   logic [31:0]   rcv_nxt_d, rd_seq_d, space_d32;
   logic [15:0]   wnd_d;
   logic          start, accept, recv_byte, room, wr_en, commit, pop, avail, issue;
   logic [D:0]    commit_len;
   logic [D-1:0]  wr_addr;
   logic [1:0]    occ;

   // Only the low D+1 bits of the modulo-2^32 distance matter, so subtract at that width.
   assign used  = rcv_nxt[D:0] - rd_seq[D:0];
   assign space = CAP[D:0] - used;

   assign start      = in_val & in_sof;
   assign accept     = start && (in_seq == rcv_nxt) && (space != '0);
   assign recv_byte  = in_val & ~in_sof & (state == RECV);
   assign room       = (cnt != space);
   assign wr_en      = ~init & (accept | (recv_byte & ~ovf & room));
   assign wr_addr    = accept ? rcv_nxt[D-1:0] : wp;
   assign commit     = in_val & in_eof & in_ok & (accept | (recv_byte & ~ovf & room));
   assign commit_len = accept ? ONE : cnt + ONE;

   assign pop   = out_val & out_rdy;
   assign avail = (fetch_seq != rcv_nxt);
   assign occ   = 2'(out_val) + 2'(skid_val) + 2'(rd_pend) - 2'(pop);
   assign issue = avail & (occ < 2'd2);

   // Window and flags are registered from next-state pointers so they line up with rcv_nxt.
   always_comb begin
      rcv_nxt_d = rcv_nxt;
      rd_seq_d  = rd_seq;
      if (init) begin
         rcv_nxt_d = isn;
         rd_seq_d  = isn;
      end else begin
         if (commit) rcv_nxt_d = rcv_nxt + 32'(commit_len);
         if (pop)    rd_seq_d  = rd_seq + 32'd1;
      end
   end

   assign used_d    = rcv_nxt_d[D:0] - rd_seq_d[D:0];
   assign space_d   = CAP[D:0] - used_d;
   assign space_d32 = 32'(space_d);
   assign wnd_d     = (space_d32 > 32'h0000_FFFF) ? 16'hFFFF : space_d32[15:0];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= in_dat;
      if (issue) ram_q <= mem[fetch_seq[D-1:0]];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rcv_nxt   <= '0;
         rd_seq    <= '0;
         fetch_seq <= '0;
         wp        <= '0;
         cnt       <= '0;
         ovf       <= 1'b0;
         rd_pend   <= 1'b0;
         skid_val  <= 1'b0;
         skid_dat  <= '0;
         out_val   <= 1'b0;
         out_dat   <= '0;
         wnd       <= WND_MAX;
         f         <= 1'b0;
         e         <= 1'b1;
      end else begin
         rcv_nxt <= rcv_nxt_d;
         rd_seq  <= rd_seq_d;
         wnd     <= wnd_d;
         f       <= (space_d <= ONE);
         e       <= (used_d == '0);
         if (init) begin
            state     <= IDLE;
            fetch_seq <= isn;
            cnt       <= '0;
            ovf       <= 1'b0;
            rd_pend   <= 1'b0;
            skid_val  <= 1'b0;
            out_val   <= 1'b0;
         end else begin
            if (start) begin
               ovf <= 1'b0;
               if (accept) begin
                  wp    <= rcv_nxt[D-1:0] + A_ONE;
                  cnt   <= ONE;
                  state <= in_eof ? IDLE : RECV;
               end else begin
                  state <= in_eof ? IDLE : DROP;
               end
            end else if (in_val) begin
               if (state == RECV) begin
                  if (!ovf && room) begin
                     wp  <= wp + A_ONE;
                     cnt <= cnt + ONE;
                  end else begin
                     ovf <= 1'b1;
                  end
               end
               if (in_eof) state <= IDLE;
            end

            // Two-deep output (out register + skid) absorbs the RAM latency without bubbles.
            if (issue) fetch_seq <= fetch_seq + 32'd1;
            rd_pend <= issue;
            if (pop || !out_val) begin
               if (skid_val) begin
                  out_dat  <= skid_dat;
                  out_val  <= 1'b1;
                  skid_val <= rd_pend;
                  skid_dat <= ram_q;
               end else if (rd_pend) begin
                  out_dat <= ram_q;
                  out_val <= 1'b1;
               end else begin
                  out_val <= 1'b0;
               end
            end else if (rd_pend) begin
               skid_val <= 1'b1;
               skid_dat <= ram_q;
            end
         end
      end
   end

endmodule
